// File: rtl/mod_counter_pkg.sv
// rtl/mod_counter_pkg.sv - shared constants, direction enum and width helper for mod_counter
package mod_counter_pkg;

   localparam int DEF_WIDTH    = 4;
   localparam int DEF_MODULUS  = 16;
   localparam int DEF_PRESCALE = 1;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   // ceil(log2(value)) but never below 1, so a 1-state prescaler still gets a real register
   function automatic int clog2_min1(input int value);
      for (int w = 1; w < 32; w++) begin
         if ((1 << w) >= value) return w;
      end
      return 32;
   endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// rtl/mod_counter_prescaler.sv - enable divider producing one tick every PRESCALE enabled cycles
module mod_counter_prescaler
   import mod_counter_pkg::*;
#(
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic clk,
   input  logic aclr_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int            PW   = clog2_min1(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pcnt_q;
   logic [PW-1:0] pcnt_d;

   assign tick = en && !clr && (pcnt_q == LAST);

   always_comb begin
      pcnt_d = pcnt_q;
      if (clr) begin
         pcnt_d = '0;
      end else if (en) begin
         pcnt_d = (pcnt_q == LAST) ? '0 : pcnt_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!aclr_n) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

endmodule

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - up/down modulo counter with prescaler, load and wrap pulse
// MOD_COUNTER_SAT_EN selects saturating limits instead of modulo wrap.
module mod_counter
   import mod_counter_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int MODULUS  = DEF_MODULUS,
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic             clk,
   input  logic             aclr_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count_out,
   output logic             wrap
);

   localparam int               XW    = WIDTH + 1;
   localparam logic [WIDTH:0]   TOP   = XW'(MODULUS - 1);
   localparam logic [WIDTH-1:0] TOP_W = TOP[WIDTH-1:0];

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             wrap_q;
   logic             wrap_d;
   logic             tick;
   logic [WIDTH:0]   cur_x;
   logic [WIDTH:0]   load_x;
   dir_e             dir;

   mod_counter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk    (clk),
      .aclr_n (aclr_n),
      .en     (en),
      .clr    (load),
      .tick   (tick)
   );

   assign dir = dir_e'(up_dn);

   // Compares run one bit wider so MODULUS == 2**WIDTH cannot alias to zero
   always_comb begin
      cur_x   = {1'b0, count_q};
      load_x  = {1'b0, load_val};
      count_d = count_q;
      wrap_d  = 1'b0;
      if (load) begin
         count_d = (load_x > TOP) ? TOP_W : load_val;
      end else if (tick) begin
         if (dir == DIR_UP) begin
            if (cur_x == TOP) begin
`ifdef MOD_COUNTER_SAT_EN
               count_d = count_q;
`else
               count_d = '0;
               wrap_d  = 1'b1;
`endif
            end else begin
               count_d = count_q + WIDTH'(1);
`ifdef MOD_COUNTER_SAT_EN
               wrap_d  = (cur_x == TOP - XW'(1));
`endif
            end
         end else begin
            if (cur_x == '0) begin
`ifdef MOD_COUNTER_SAT_EN
               count_d = count_q;
`else
               count_d = TOP_W;
               wrap_d  = 1'b1;
`endif
            end else begin
               count_d = count_q - WIDTH'(1);
`ifdef MOD_COUNTER_SAT_EN
               wrap_d  = (cur_x == XW'(1));
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!aclr_n) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count_out = count_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - scoreboard bench for mod_counter in three configurations
module tb_mod_counter;

`ifdef MOD_COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   localparam int DUT_A = 0;  // WIDTH 4, MODULUS 10, PRESCALE 1
   localparam int DUT_B = 1;  // WIDTH 4, MODULUS 10, PRESCALE 3
   localparam int DUT_C = 2;  // WIDTH 3, MODULUS 8,  PRESCALE 2

   typedef struct {
      int    sel;
      int    cnt;
      logic  wrp;
      bit    chk;
      string nm;
   } exp_t;

   logic       clk = 1'b0;
   logic       aclr_n;
   logic       en;
   logic       up_dn;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] count_a;
   logic [3:0] count_b;
   logic [2:0] count_c;
   logic       wrap_a;
   logic       wrap_b;
   logic       wrap_c;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_dut_a (
      .clk(clk), .aclr_n(aclr_n), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .count_out(count_a), .wrap(wrap_a));

   mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u_dut_b (
      .clk(clk), .aclr_n(aclr_n), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .count_out(count_b), .wrap(wrap_b));

   mod_counter #(.WIDTH(3), .MODULUS(8), .PRESCALE(2)) u_dut_c (
      .clk(clk), .aclr_n(aclr_n), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val[2:0]), .count_out(count_c), .wrap(wrap_c));

   // Drive one cycle of stimulus and queue the outputs expected after the next edge
   task automatic cyc(input int sel, input logic r, input logic e, input logic u,
                      input logic l, input logic [3:0] lv, input int ec,
                      input logic ew, input bit chk, input string nm);
      exp_t x;
      @(negedge clk);
      aclr_n   = r;
      en       = e;
      up_dn    = u;
      load     = l;
      load_val = lv;
      x.sel = sel;
      x.cnt = ec;
      x.wrp = ew;
      x.chk = chk;
      x.nm  = nm;
      sb.push_back(x);
   endtask

   initial begin : monitor
      exp_t x;
      int   act_cnt;
      logic act_wrp;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            case (x.sel)
               DUT_A:   begin act_cnt = int'(count_a); act_wrp = wrap_a; end
               DUT_B:   begin act_cnt = int'(count_b); act_wrp = wrap_b; end
               default: begin act_cnt = int'(count_c); act_wrp = wrap_c; end
            endcase
            if (x.chk) begin
               n_checks++;
               if (act_cnt == x.cnt && act_wrp === x.wrp) begin
                  n_pass++;
               end else begin
                  $display("FAIL %s: count=%0d wrap=%b, expected count=%0d wrap=%b",
                           x.nm, act_cnt, act_wrp, x.cnt, x.wrp);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int en_seq[11];
      int ex_seq[11];
      aclr_n   = 1'b0;
      en       = 1'b0;
      up_dn    = 1'b1;
      load     = 1'b0;
      load_val = 4'd0;

      // Reset beats load and enable on every instance
      cyc(DUT_A, 0, 1, 1, 1, 4'd5, 0, 0, 1, "reset_a");
      cyc(DUT_B, 0, 1, 1, 1, 4'd5, 0, 0, 1, "reset_b");
      cyc(DUT_C, 0, 1, 1, 1, 4'd5, 0, 0, 1, "reset_c");

      // Up count 0..9 then wrap (saturating build holds at 9)
      for (int i = 1; i <= 11; i++) begin
         if (SAT) cyc(DUT_A, 1, 1, 1, 0, 4'd0, (i > 9) ? 9 : i, (i == 9), 1, "up_run");
         else     cyc(DUT_A, 1, 1, 1, 0, 4'd0, i % 10, (i == 10), 1, "up_run");
      end

      // Limit behaviour from 8
      cyc(DUT_A, 1, 1, 1, 1, 4'd8, 8, 0, 1, "load8");
      cyc(DUT_A, 1, 1, 1, 0, 4'd0, 9, SAT ? 1'b1 : 1'b0, 1, "up_8_to_9");
      cyc(DUT_A, 1, 1, 1, 0, 4'd0, SAT ? 9 : 0, SAT ? 1'b0 : 1'b1, 1, "up_at_top");
      cyc(DUT_A, 1, 1, 0, 0, 4'd0, SAT ? 8 : 9, SAT ? 1'b0 : 1'b1, 1, "dir_switch");

      // Down from 0
      cyc(DUT_A, 1, 1, 0, 1, 4'd0, 0, 0, 1, "load0");
      cyc(DUT_A, 1, 1, 0, 0, 4'd0, SAT ? 0 : 9, SAT ? 1'b0 : 1'b1, 1, "down_wrap");
      cyc(DUT_A, 1, 1, 0, 0, 4'd0, SAT ? 0 : 8, 0, 1, "down_8");
      cyc(DUT_A, 1, 1, 0, 0, 4'd0, SAT ? 0 : 7, 0, 1, "down_7");

      // Load while counting, clamp, hold, load beating a would-be wrap
      cyc(DUT_A, 1, 1, 1, 1, 4'd6,  6, 0, 1, "load6_with_en");
      cyc(DUT_A, 1, 1, 1, 0, 4'd0,  7, 0, 1, "after_load6");
      cyc(DUT_A, 1, 1, 1, 1, 4'd12, 9, 0, 1, "load12_clamp");
      cyc(DUT_A, 1, 0, 1, 0, 4'd0,  9, 0, 1, "hold_en0");
      cyc(DUT_A, 1, 1, 1, 1, 4'd15, 9, 0, 1, "load15_over_wrap");

      // Prescale 3 with a 2-cycle enable gap mid-phase
      cyc(DUT_B, 0, 1, 1, 0, 4'd0, 0, 0, 1, "reset_b2");
      en_seq = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
      ex_seq = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3};
      for (int i = 0; i < 11; i++) begin
         cyc(DUT_B, 1, en_seq[i][0], 1, 0, 4'd0, ex_seq[i], 0, 1, "prescale");
      end
      cyc(DUT_B, 1, 1, 1, 0, 4'd0, 3, 0, 1, "pre_phase1");
      cyc(DUT_B, 1, 1, 1, 1, 4'd4, 4, 0, 1, "pre_load_clr");
      cyc(DUT_B, 1, 1, 1, 0, 4'd0, 4, 0, 1, "pre_after_load1");
      cyc(DUT_B, 1, 1, 1, 0, 4'd0, 4, 0, 1, "pre_after_load2");
      cyc(DUT_B, 1, 1, 1, 0, 4'd0, 5, 0, 1, "pre_after_load3");

      // Full range (MODULUS == 2**WIDTH), reset mid-phase
      cyc(DUT_C, 1, 1, 1, 1, 4'd7, 7, 0, 1, "full_load7");
      cyc(DUT_C, 1, 1, 1, 0, 4'd0, 7, 0, 1, "full_phase");
      cyc(DUT_C, 1, 1, 1, 0, 4'd0, SAT ? 7 : 0, SAT ? 1'b0 : 1'b1, 1, "full_up_top");
      cyc(DUT_C, 1, 1, 1, 0, 4'd0, SAT ? 7 : 0, 0, 1, "full_wrap_once");
      cyc(DUT_C, 0, 1, 1, 0, 4'd0, 0, 0, 1, "full_reset_mid");
      cyc(DUT_C, 1, 1, 1, 0, 4'd0, 0, 0, 1, "full_post_rst1");
      cyc(DUT_C, 1, 1, 1, 0, 4'd0, 1, 0, 1, "full_post_rst2");
      cyc(DUT_C, 1, 1, 0, 0, 4'd0, 1, 0, 1, "full_dn_phase");
      cyc(DUT_C, 1, 1, 0, 0, 4'd0, 0, SAT ? 1'b1 : 1'b0, 1, "full_dn_to0");
      cyc(DUT_C, 1, 1, 0, 0, 4'd0, 0, 0, 1, "full_dn_phase2");
      cyc(DUT_C, 1, 1, 0, 0, 4'd0, SAT ? 0 : 7, SAT ? 1'b0 : 1'b1, 1, "full_dn_bottom");

      cyc(DUT_A, 1, 0, 1, 0, 4'd0, 0, 0, 0, "idle");
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
